// File: rtl/fb_vga_reader.sv
// -----------------------------------------------------------------------------
// fb_vga_reader
//
// Scans a VGA raster (640x480 active area at the default timing) and fetches
// a smaller, centred image from a framebuffer. The image is either 1/2, 1/8
// or 1/4 of the active area in each dimension; at the default timing that is
// 320x240, 80x60 or 160x120. Pixels outside the image window, and every
// pixel of a frame that started without a complete framebuffer, are shown
// as 0.
//
// The format and the framebuffer-ready flag are sampled only at raster
// position (0,0), so a frame is always drawn with one consistent setting.
//
// Pipeline (one pixel per clock):
//   t   : h_cnt / v_cnt
//   t+1 : ram_rdaddr registered
//   t+2 : ram_q returned by the framebuffer
//   t+3 : pixel_out, hsync, vsync, de, frame_start registered
//
// Ports
//   clk          pixel clock
//   reset        synchronous, active-high
//   seletor[1:0] image format: 00 -> 1/2, 01 -> 1/8, 10/11 -> 1/4 of active
//   img_ready    framebuffer holds a complete image
//   ram_rdaddr   framebuffer read address (row-major within the image)
//   ram_q        framebuffer data, valid one clock after ram_rdaddr
//   pixel_out    displayed pixel
//   hsync/vsync  active-low sync pulses
//   de           high inside the active area
//   frame_start  one-clock pulse together with output pixel (0,0)
// -----------------------------------------------------------------------------
module fb_vga_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  seletor,
  input  logic        img_ready,
  output logic [18:0] ram_rdaddr,
  input  logic [7:0]  ram_q,
  output logic [7:0]  pixel_out,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = 19;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // Raster boundaries, widened to the address width so every compare and
  // subtraction below happens at one unsigned width.
  localparam logic [AW-1:0] HA     = AW'(H_ACTIVE);
  localparam logic [AW-1:0] VA     = AW'(V_ACTIVE);
  localparam logic [AW-1:0] HS_BEG = AW'(H_ACTIVE + H_FP);
  localparam logic [AW-1:0] HS_END = AW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [AW-1:0] VS_BEG = AW'(V_ACTIVE + V_FP);
  localparam logic [AW-1:0] VS_END = AW'(V_ACTIVE + V_FP + V_SYNC);

  // Image sizes for each format
  localparam logic [AW-1:0] W_HALF    = AW'(H_ACTIVE / 2);
  localparam logic [AW-1:0] H_HALF    = AW'(V_ACTIVE / 2);
  localparam logic [AW-1:0] W_EIGHTH  = AW'(H_ACTIVE / 8);
  localparam logic [AW-1:0] H_EIGHTH  = AW'(V_ACTIVE / 8);
  localparam logic [AW-1:0] W_QUARTER = AW'(H_ACTIVE / 4);
  localparam logic [AW-1:0] H_QUARTER = AW'(V_ACTIVE / 4);

  // Control bits that travel alongside the pixel fetch
  typedef struct packed {
    logic hs;    // hsync level (active low)
    logic vs;    // vsync level (active low)
    logic de;    // inside active area
    logic show;  // inside image window and framebuffer ready
    logic fs;    // raster position (0,0)
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(5'b11000);
  localparam int    CTRL_DLY  = 2;  // stages between counters and output regs

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          frame_top;

  assign frame_top = (h_cnt_reg == '0) && (v_cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + HW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-frame settings, sampled at (0,0) only
  // ---------------------------------------------------------------------------
  logic [1:0] fmt_reg;
  logic       rdy_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      fmt_reg <= 2'b10;
      rdy_reg <= 1'b0;
    end else if (frame_top) begin
      fmt_reg <= seletor;
      rdy_reg <= img_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Window geometry and address generation
  // ---------------------------------------------------------------------------
  logic [AW-1:0] h_ext;
  logic [AW-1:0] v_ext;
  logic [AW-1:0] win_w;
  logic [AW-1:0] win_h;
  logic [AW-1:0] x0;
  logic [AW-1:0] y0;
  logic          in_win;
  logic [AW-1:0] addr_next;
  ctrl_t         ctrl_next;

  assign h_ext = AW'(h_cnt_reg);
  assign v_ext = AW'(v_cnt_reg);

  always_comb begin
    win_w = W_QUARTER;
    win_h = H_QUARTER;
    case (fmt_reg)
      2'b00: begin
        win_w = W_HALF;
        win_h = H_HALF;
      end
      2'b01: begin
        win_w = W_EIGHTH;
        win_h = H_EIGHTH;
      end
      default: begin
        win_w = W_QUARTER;
        win_h = H_QUARTER;
      end
    endcase
  end

  assign x0 = (HA - win_w) >> 1;
  assign y0 = (VA - win_h) >> 1;

  assign in_win = (h_ext >= x0) && (h_ext < x0 + win_w) &&
                  (v_ext >= y0) && (v_ext < y0 + win_h);

  // Outside the window the address parks at 0, so it never exceeds W*H-1.
  always_comb begin
    addr_next = '0;
    if (in_win) begin
      addr_next = (v_ext - y0) * win_w + (h_ext - x0);
    end
  end

  always_comb begin
    ctrl_next      = CTRL_IDLE;
    ctrl_next.hs   = !((h_ext >= HS_BEG) && (h_ext < HS_END));
    ctrl_next.vs   = !((v_ext >= VS_BEG) && (v_ext < VS_END));
    ctrl_next.de   = (h_ext < HA) && (v_ext < VA);
    ctrl_next.show = in_win && rdy_reg;
    ctrl_next.fs   = frame_top;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_rdaddr <= '0;
    end else begin
      ram_rdaddr <= addr_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Control delay line: keeps sync/de/window aligned with the returning pixel
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CTRL_DLY; gi++) begin : g_stage
      ctrl_t q;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (reset) begin
            q <= CTRL_IDLE;
          end else begin
            q <= ctrl_next;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (reset) begin
            q <= CTRL_IDLE;
          end else begin
            q <= g_stage[gi-1].q;
          end
        end
      end
    end
  endgenerate

  ctrl_t ctrl_d;
  assign ctrl_d = g_stage[CTRL_DLY-1].q;

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out   <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // show already implies the active area; de is kept in the gate so
      // blanking can never carry image data.
      pixel_out   <= (ctrl_d.show && ctrl_d.de) ? ram_q : '0;
      hsync       <= ctrl_d.hs;
      vsync       <= ctrl_d.vs;
      de          <= ctrl_d.de;
      frame_start <= ctrl_d.fs;
    end
  end

endmodule

// File: tb/tb_fb_vga_reader.sv
// Testbench for fb_vga_reader using a scaled-down raster (64x32 active,
// 80 clocks per line, 38 lines per frame) so whole frames fit in a short run.
// Image formats at this size: 00 -> 32x16 at (16,8), 01 -> 8x4 at (28,14),
// 10/11 -> 16x8 at (24,12).
module tb_fb_vga_reader;

  localparam int HA    = 64;
  localparam int HF    = 4;
  localparam int HS    = 8;
  localparam int HB    = 4;
  localparam int VA    = 32;
  localparam int VF    = 2;
  localparam int VS    = 2;
  localparam int VB    = 2;
  localparam int HT    = HA + HF + HS + HB;  // 80
  localparam int VT    = VA + VF + VS + VB;  // 38
  localparam int FRAME = HT * VT;            // 3040

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  seletor = 2'b10;
  logic        img_ready = 1'b0;
  logic [18:0] ram_rdaddr;
  logic [7:0]  ram_q = 8'd0;
  logic [7:0]  pixel_out;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic        frame_start;

  int total = 0;
  int bad   = 0;
  int e     = 0;  // clock edges since the last reset release

  fb_vga_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .seletor    (seletor),
    .img_ready  (img_ready),
    .ram_rdaddr (ram_rdaddr),
    .ram_q      (ram_q),
    .pixel_out  (pixel_out),
    .hsync      (hsync),
    .vsync      (vsync),
    .de         (de),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: a fixed pattern of the address
  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  always @(posedge clk) ram_q <= pat(int'(ram_rdaddr));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d (e=%0d)", name, got, exp, e);
    end else begin
      $display("ok   %s got=%0d (e=%0d)", name, got, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    e++;
  endtask

  // After e edges, ram_rdaddr reflects raster position e-1 and the output
  // registers reflect position e-3.
  task automatic run_to(input int target);
    if (target < e) begin
      total++;
      bad++;
      $display("FAIL run_to target=%0d already at e=%0d", target, e);
    end
    while (e < target) tick();
  endtask

  task automatic do_reset(input logic [1:0] sel, input logic rdy);
    reset     = 1'b1;
    seletor   = sel;
    img_ready = rdy;
    tick();
    tick();
    reset = 1'b0;
    e     = 0;
  endtask

  typedef struct {
    logic [1:0] sel;
    logic       rdy;
    int         h;
    int         v;
    int         addr;
    logic       data;
    logic       de;
    logic       hs;
    logic       vs;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] sel, input logic rdy, input int h, input int v,
                     input int addr, input logic data, input logic d,
                     input logic hs_l, input logic vs_l);
    vec_t r;
    r.sel = sel; r.rdy = rdy; r.h = h; r.v = v; r.addr = addr;
    r.data = data; r.de = d; r.hs = hs_l; r.vs = vs_l;
    vecs.push_back(r);
  endtask

  initial begin
    vec_t r;
    int   p;
    int   key;
    int   cur_key;
    int   hs_low, vs_low, de_cnt, fs_cnt, first_hs, first_vs, first_fs, nz;

    // ---------------- reset state ----------------
    reset = 1'b1;
    tick();
    tick();
    check("rst_addr", 32'(ram_rdaddr), 0);
    check("rst_pixel", 32'(pixel_out), 0);
    check("rst_de", 32'(de), 0);
    check("rst_hsync", 32'(hsync), 1);
    check("rst_vsync", 32'(vsync), 1);
    check("rst_fs", 32'(frame_start), 0);

    // ---------------- vector table ----------------
    //   sel    rdy   h   v  addr data de hs vs
    add(2'b00, 1'b1, 16,  8,   0, 1, 1, 1, 1);  // first image pixel
    add(2'b00, 1'b1, 15,  8,   0, 0, 1, 1, 1);  // one left of window
    add(2'b00, 1'b1, 47,  8,  31, 1, 1, 1, 1);  // last pixel of first row
    add(2'b00, 1'b1, 48,  8,   0, 0, 1, 1, 1);  // one right of window
    add(2'b00, 1'b1, 16,  9,  32, 1, 1, 1, 1);  // start of second row
    add(2'b00, 1'b1, 47, 23, 511, 1, 1, 1, 1);  // last image pixel
    add(2'b00, 1'b1, 16, 24,   0, 0, 1, 1, 1);  // one below window
    add(2'b00, 1'b1, 70, 24,   0, 0, 0, 0, 1);  // inside hsync
    add(2'b00, 1'b1, 10, 34,   0, 0, 0, 1, 0);  // inside vsync
    add(2'b01, 1'b1, 28, 13,   0, 0, 1, 1, 1);  // one above window
    add(2'b01, 1'b1, 28, 14,   0, 1, 1, 1, 1);
    add(2'b01, 1'b1, 35, 17,  31, 1, 1, 1, 1);  // last image pixel
    add(2'b01, 1'b1, 36, 17,   0, 0, 1, 1, 1);
    add(2'b10, 1'b1, 24, 12,   0, 1, 1, 1, 1);
    add(2'b10, 1'b1, 23, 19,   0, 0, 1, 1, 1);
    add(2'b10, 1'b1, 39, 19, 127, 1, 1, 1, 1);  // last image pixel
    add(2'b10, 1'b1, 40, 19,   0, 0, 1, 1, 1);
    add(2'b11, 1'b1, 39, 19, 127, 1, 1, 1, 1);  // 11 behaves like 10
    add(2'b11, 1'b1, 24, 20,   0, 0, 1, 1, 1);
    add(2'b00, 1'b0, 16,  8,   0, 0, 1, 1, 1);  // not ready: blank image
    add(2'b00, 1'b0, 47, 23, 511, 0, 1, 1, 1);

    cur_key = -1;
    foreach (vecs[i]) begin
      r   = vecs[i];
      p   = r.v * HT + r.h;
      key = int'({r.sel, r.rdy});
      if (key != cur_key || p + 1 < e) begin
        do_reset(r.sel, r.rdy);
        cur_key = key;
      end
      $display("vec %0d sel=%b rdy=%0d pos=(%0d,%0d)", i, r.sel, r.rdy, r.h, r.v);
      run_to(p + 1);
      check($sformatf("v%0d_addr", i), 32'(ram_rdaddr), 32'(r.addr));
      run_to(p + 3);
      check($sformatf("v%0d_pixel", i), 32'(pixel_out), r.data ? 32'(pat(r.addr)) : 32'd0);
      check($sformatf("v%0d_de", i), 32'(de), 32'(r.de));
      check($sformatf("v%0d_hsync", i), 32'(hsync), 32'(r.hs));
      check($sformatf("v%0d_vsync", i), 32'(vsync), 32'(r.vs));
    end

    // ---------------- free-running frame timing ----------------
    do_reset(2'b10, 1'b1);
    hs_low = 0; vs_low = 0; de_cnt = 0; fs_cnt = 0;
    first_hs = -1; first_vs = -1; first_fs = -1;
    while (e < FRAME + 2) begin
      tick();
      if (!hsync) begin
        hs_low++;
        if (first_hs < 0) first_hs = e;
      end
      if (!vsync) begin
        vs_low++;
        if (first_vs < 0) first_vs = e;
      end
      if (de) de_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = e;
      end
    end
    check("frame_fs_first", 32'(first_fs), 3);
    check("frame_fs_count", 32'(fs_cnt), 1);
    check("frame_hs_first", 32'(first_hs), 32'(HA + HF + 3));
    check("frame_hs_low", 32'(hs_low), 32'(HS * VT));
    check("frame_vs_first", 32'(first_vs), 32'((VA + VF) * HT + 3));
    check("frame_vs_low", 32'(vs_low), 32'(VS * HT));
    check("frame_de_count", 32'(de_cnt), 32'(HA * VA));
    tick();
    check("frame_fs_next", 32'(frame_start), 1);

    // ---------------- img_ready raised mid-frame ----------------
    do_reset(2'b00, 1'b0);
    nz = 0;
    while (e < FRAME + 2) begin
      tick();
      if (e == 100) img_ready = 1'b1;
      if (pixel_out != 8'd0) nz++;
    end
    check("rdy_mid_nonzero", 32'(nz), 0);
    run_to(FRAME + 8 * HT + 16 + 3);
    check("rdy_next_pixel", 32'(pixel_out), 32'(pat(0)));

    // ---------------- format change mid-frame ----------------
    do_reset(2'b00, 1'b1);
    run_to(5 * HT + 1);
    seletor = 2'b01;
    run_to(23 * HT + 47 + 1);
    check("fmt_cur_addr", 32'(ram_rdaddr), 511);
    run_to(FRAME + 17 * HT + 35 + 1);
    check("fmt_next_addr", 32'(ram_rdaddr), 31);
    run_to(FRAME + 17 * HT + 35 + 3);
    check("fmt_next_pixel", 32'(pixel_out), 32'(pat(31)));
    run_to(FRAME + 23 * HT + 47 + 1);
    check("fmt_next_outside", 32'(ram_rdaddr), 0);

    // ---------------- reset in the middle of a frame ----------------
    do_reset(2'b00, 1'b1);
    run_to(10 * HT + 30 + 3);
    check("mid_pixel", 32'(pixel_out), 32'(pat(78)));
    check("mid_de", 32'(de), 1);
    reset = 1'b1;
    tick();
    check("mid_rst_addr", 32'(ram_rdaddr), 0);
    check("mid_rst_pixel", 32'(pixel_out), 0);
    check("mid_rst_de", 32'(de), 0);
    check("mid_rst_hsync", 32'(hsync), 1);
    check("mid_rst_vsync", 32'(vsync), 1);
    check("mid_rst_fs", 32'(frame_start), 0);
    reset = 1'b0;
    e = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("rel_fs_e%0d", k), 32'(frame_start), (k == 3) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fb_vga_reader.md
FB_VGA_READER -- requirements
Module: fb_vga_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP 16, H_SYNC 96, H_BP 48, the horizontal porch and sync lengths in clocks.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33, the vertical lengths in lines.
REQ-004 SHALL have port clk, input, 1, the single clock (pixel clock), one pixel per cycle.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high.
REQ-006 SHALL have port seletor, input, 2, image format: 00 gives 320x240, 01 gives 80x60, 10 and 11 give 160x120.
REQ-007 SHALL have port img_ready, input, 1, framebuffer-complete flag from the writer.
REQ-008 SHALL have port ram_rdaddr, output, 19, framebuffer read address.
REQ-009 SHALL have port ram_q, input, 8, framebuffer read data, valid one clock after ram_rdaddr.
REQ-010 SHALL have port pixel_out, output, 8, displayed pixel.
REQ-011 SHALL have ports hsync and vsync, outputs, 1 each, active-low sync pulses.
REQ-012 SHALL have port de, output, 1, high during the 640x480 active area.
REQ-013 SHALL have port frame_start, output, 1, one-clock pulse aligned with output pixel (0,0).

Function
REQ-014 SHALL count h_cnt 0..799 and wrap to 0; v_cnt SHALL increment on each h wrap, counting 0..524 and wrapping to 0.
REQ-015 SHALL define the sync regions as: hsync low for h_cnt 656..751; vsync low for v_cnt 490..491; de high for h_cnt<640 and v_cnt<480.
REQ-016 SHALL latch seletor and img_ready into frame registers only when h_cnt=0 and v_cnt=0; mid-frame changes take effect at the next frame.
REQ-017 SHALL derive the image window from the latched format: W,H; x0=(640-W)/2, y0=(480-H)/2; window is x0<=h_cnt<x0+W and y0<=v_cnt<y0+H.
REQ-018 SHALL register ram_rdaddr=(v_cnt-y0)*W+(h_cnt-x0) when inside the window, else 0, with all arithmetic at 19 bits unsigned.
REQ-019 SHALL use a 3-stage pipeline: counters at cycle t, ram_rdaddr at t+1, ram_q at t+2, and hsync/vsync/de/pixel_out/frame_start registered at t+3.
REQ-020 SHALL delay hsync, vsync, de and the in-window flag by exactly 3 clocks so they stay aligned with pixel_out.
REQ-021 SHALL output pixel_out=ram_q when the delayed in-window flag is 1 and the latched img_ready is 1; otherwise pixel_out SHALL be 0.
REQ-022 SHALL hold pixel_out at 0 whenever de=0.
REQ-023 SHALL never produce ram_rdaddr >= W*H.

Reset
REQ-024 SHALL, on reset, set h_cnt=0, v_cnt=0, ram_rdaddr=0, pixel_out=0, de=0, hsync=1, vsync=1, frame_start=0, all pipeline stages to their inactive values, latched format=10, and latched img_ready=0.
REQ-025 SHALL let reset asserted mid-frame take effect on the next clock edge; after release, counting SHALL restart at (0,0) and frame_start SHALL fire 3 clocks after release.

Verification
REQ-026 seletor=00, img_ready=1 -> ram_rdaddr=0 for counters (160,120); 76799 for (479,359); pixel_out=0 at (159,120) and ram_q at (160,120), each 3 clocks later.
REQ-027 seletor=01 -> window x 280..359, y 210..269; last address 4799 at (359,269); seletor=10 -> window 240..399 x 180..299, last address 19199.
REQ-028 Free-run -> line period 800 clocks, hsync low 96 clocks starting 656 clocks into the line; frame period 420000 clocks; vsync low for lines 490..491; one frame_start per frame.
REQ-029 img_ready=0 at frame start, raised mid-frame -> entire frame pixel_out=0; the next frame shows image data.
REQ-030 seletor 00 changed to 01 mid-frame -> the current frame keeps the 320x240 window; the next frame uses 80x60.
REQ-031 reset pulsed at h=300, v=100 -> next clock outputs at reset values; frame_start pulses 3 clocks after reset release.
